// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder pipeline.
// Provides the operand classification enum, exponent bias helper, the
// canonical quiet-NaN constant builder and the bit positions of the
// exception flags inside the 4-bit flags word.
package fp_pkg;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

  // Bit positions in flags = {invalid, overflow, underflow, inexact}
  localparam int FL_INV = 3;
  localparam int FL_OVF = 2;
  localparam int FL_UNF = 1;
  localparam int FL_INX = 0;

  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // Canonical qNaN {0, all-ones exponent, 1, 0...}; callers truncate to
  // their word width.
  function automatic logic [127:0] qnan(input int ew, input int mw);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < ew; i++) r[mw + i] = 1'b1;
    r[mw - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter.
// Ports: vec   - input vector, MSB first
//        count - number of zeros above the highest set bit (W when vec==0)
module fp_lzc #(
  parameter int W = 8
) (
  input  logic [W-1:0]             vec,
  output logic [$clog2(W+1)-1:0]   count
);

  localparam int CW = $clog2(W + 1);

  // Scanning upwards lets the highest set bit win.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (vec[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fadd_pipe.sv
// Four-stage pipelined floating-point adder/subtractor with valid/ready
// handshake, round-to-nearest-even, flush-to-zero and exception flags.
// Ports: clk, rst (sync, active-high)
//        in_valid/in_ready, a, b, sub  - operand side (sub=1: a - b)
//        out_valid/out_ready, out, flags - result side,
//        flags = {invalid, overflow, underflow, inexact}
// All stages advance together whenever the output is empty or drained.
module fadd_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int N     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic [3:0]   flags
);

  localparam int SW  = MAN_W + 4;            // hidden + fraction + g,r,s
  localparam int W5  = MAN_W + 5;            // SW plus carry
  localparam int LZW = $clog2(SW + 1);
  localparam int XW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam logic [N-1:0] QNAN = N'(qnan(EXP_W, MAN_W));

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                         input logic [MAN_W-1:0] m);
    if (e == '0) return FP_ZERO;             // subnormals flush here
    if (e == '1) return (m == '0) ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

  function automatic logic rne_inc(input logic lsb, input logic g,
                                   input logic rs);
    return g & (rs | lsb);
  endfunction

  // Saturating pack: returns {flags, word}.
  function automatic logic [N+3:0] pack_sat(input logic s,
                                            input logic signed [XW-1:0] e,
                                            input logic [MAN_W-1:0] f,
                                            input logic inx);
    logic signed [XW-1:0] emax;
    logic [3:0]           fl;
    logic [N-1:0]         w;
    emax = XW'({EXP_W{1'b1}});
    fl   = 4'b0;
    if (e >= emax) begin
      w = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      fl[FL_OVF] = 1'b1;
      fl[FL_INX] = 1'b1;
    end else if (e[XW-1] || e == '0) begin
      w = {s, {(N-1){1'b0}}};
      fl[FL_UNF] = 1'b1;
      fl[FL_INX] = 1'b1;
    end else begin
      w = {s, e[EXP_W-1:0], f};
      fl[FL_INX] = inx;
    end
    return {fl, w};
  endfunction

  logic adv;
  logic vld_p1, vld_p2, vld_p3, vld_p4;

  assign adv       = !vld_p4 || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p4;

  always_ff @(posedge clk) begin
    if (rst) {vld_p1, vld_p2, vld_p3, vld_p4} <= '0;
    else if (adv) {vld_p1, vld_p2, vld_p3, vld_p4} <= {in_valid, vld_p1, vld_p2, vld_p3};
  end

  // ---- stage 1: unpack, classify, special cases, magnitude swap ----
  logic             sa, sb, a_big, spc;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  fp_class_e        ca, cb;
  logic [N-1:0]     spc_res;
  logic [3:0]       spc_flg;

  assign sa    = a[N-1];
  assign ea    = a[N-2:MAN_W];
  assign ma    = a[MAN_W-1:0];
  assign sb    = b[N-1] ^ sub;
  assign eb    = b[N-2:MAN_W];
  assign mb    = b[MAN_W-1:0];
  assign ca    = classify(ea, ma);
  assign cb    = classify(eb, mb);
  assign a_big = {ea, ma} >= {eb, mb};

  always_comb begin
    spc     = 1'b1;
    spc_res = '0;
    spc_flg = '0;
    if (ca == FP_NAN || cb == FP_NAN) begin
      spc_res = QNAN;
      spc_flg[FL_INV] = (ca == FP_NAN && !ma[MAN_W-1]) || (cb == FP_NAN && !mb[MAN_W-1]);
    end else if (ca == FP_INF && cb == FP_INF) begin
      if (sa != sb) begin
        spc_res = QNAN;
        spc_flg[FL_INV] = 1'b1;
      end else begin
        spc_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
    end else if (ca == FP_INF) begin
      spc_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cb == FP_INF) begin
      spc_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ca == FP_ZERO && cb == FP_ZERO) begin
      spc_res = {sa & sb, {(N-1){1'b0}}};    // only -0 + -0 stays negative
    end else if (ca == FP_ZERO) begin
      spc_res = {sb, eb, mb};
    end else if (cb == FP_ZERO) begin
      spc_res = {sa, ea, ma};
    end else begin
      spc = 1'b0;
    end
  end

  logic             sx_p1, eff_sub_p1, spc_p1;
  logic [EXP_W-1:0] ex_p1, d_p1;
  logic [MAN_W-1:0] mx_p1, my_p1;
  logic [N-1:0]     spc_res_p1;
  logic [3:0]       spc_flg_p1;

  always_ff @(posedge clk) begin
    if (adv) begin
      sx_p1      <= a_big ? sa : sb;
      ex_p1      <= a_big ? ea : eb;
      d_p1       <= a_big ? ea - eb : eb - ea;
      mx_p1      <= a_big ? ma : mb;
      my_p1      <= a_big ? mb : ma;
      eff_sub_p1 <= sa ^ sb;
      spc_p1     <= spc;
      spc_res_p1 <= spc_res;
      spc_flg_p1 <= spc_flg;
    end
  end

  // ---- stage 2: align smaller significand with sticky collection ----
  int            sh;
  logic [SW-1:0] sigy, mask, aligned;

  always_comb begin
    sh      = (int'(d_p1) > MAN_W + 3) ? MAN_W + 3 : int'(d_p1);
    sigy    = {1'b1, my_p1, 3'b000};
    mask    = (SW'(1) << sh) - SW'(1);
    aligned = (sigy >> sh) | SW'(|(sigy & mask));
  end

  logic             sx_p2, eff_sub_p2, spc_p2;
  logic [EXP_W-1:0] ex_p2;
  logic [MAN_W-1:0] mx_p2;
  logic [SW-1:0]    sigy_p2;
  logic [N-1:0]     spc_res_p2;
  logic [3:0]       spc_flg_p2;

  always_ff @(posedge clk) begin
    if (adv) begin
      sx_p2      <= sx_p1;
      ex_p2      <= ex_p1;
      mx_p2      <= mx_p1;
      sigy_p2    <= aligned;
      eff_sub_p2 <= eff_sub_p1;
      spc_p2     <= spc_p1;
      spc_res_p2 <= spc_res_p1;
      spc_flg_p2 <= spc_flg_p1;
    end
  end

  // ---- stage 3: significand add/subtract (X >= Y, never negative) ----
  logic [W5-1:0] sigx5, sum;

  assign sigx5 = {2'b01, mx_p2, 3'b000};
  assign sum   = eff_sub_p2 ? sigx5 - {1'b0, sigy_p2} : sigx5 + {1'b0, sigy_p2};

  logic             sx_p3, spc_p3;
  logic [EXP_W-1:0] ex_p3;
  logic [W5-1:0]    sum_p3;
  logic [N-1:0]     spc_res_p3;
  logic [3:0]       spc_flg_p3;

  always_ff @(posedge clk) begin
    if (adv) begin
      sx_p3      <= sx_p2;
      ex_p3      <= ex_p2;
      sum_p3     <= sum;
      spc_p3     <= spc_p2;
      spc_res_p3 <= spc_res_p2;
      spc_flg_p3 <= spc_flg_p2;
    end
  end

  // ---- stage 4: normalise, round, pack ----
  logic [LZW-1:0]       lz;
  logic [SW-1:0]        norm;
  logic signed [XW-1:0] ex_s, lz_s, exp_n, exp_r;
  logic [MAN_W+1:0]     rnd;
  logic [MAN_W-1:0]     frac;
  logic                 inx;
  logic [N-1:0]         res4;
  logic [3:0]           flg4;

  fp_lzc #(.W(SW)) u_lzc (.vec(sum_p3[SW-1:0]), .count(lz));

  always_comb begin
    ex_s = XW'(ex_p3);
    lz_s = XW'(lz);
    if (sum_p3[W5-1]) begin
      norm  = {sum_p3[W5-1:2], sum_p3[1] | sum_p3[0]};
      exp_n = ex_s + XW'(1);
    end else begin
      norm  = sum_p3[SW-1:0] << lz;
      exp_n = ex_s - lz_s;
    end
    inx = |norm[2:0];
    rnd = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(rne_inc(norm[3], norm[2], |norm[1:0]));
    if (rnd[MAN_W+1]) begin
      exp_r = exp_n + XW'(1);
      frac  = rnd[MAN_W:1];
    end else begin
      exp_r = exp_n;
      frac  = rnd[MAN_W-1:0];
    end
    if (spc_p3) {flg4, res4} = {spc_flg_p3, spc_res_p3};
    else if (sum_p3 == '0) {flg4, res4} = '0;   // exact cancellation gives +0
    else {flg4, res4} = pack_sat(sx_p3, exp_r, frac, inx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      flags <= '0;
    end else if (adv && vld_p3) begin
      out   <= res4;
      flags <= flg4;
    end
  end

endmodule
